// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side frame buffer behind the UART receiver. Each completed frame
//   (a `done` pulse, or the rising edge of `stop_error`) becomes one entry of
//   {frame_err, parity_err, data} in a DEPTH-entry circular FIFO. Entries are
//   presented first-word-fall-through on a valid/ready read port.
//
// Parameters
//   UART_SIZE  data bits per frame
//   DEPTH      FIFO entries (power of two, >= 2)
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   rx_data, done       receiver data word and its one-cycle strobe
//   crc_error           receiver parity-error level, captured with each event
//   stop_error          receiver framing-error level; rising edge = event
//   flush               discard all entries (and any same-cycle event)
//   clear_overflow      clear the sticky overflow flag
//   rd_valid/rd_ready   read handshake; pop when both are high
//   rd_data, rd_parity_err, rd_frame_err   head entry
//   count, empty, full  registered occupancy
//   overflow            sticky: an event was dropped because the FIFO was full
//   err_drop_count      saturating count of discarded error events
//
// Build option
//   UART_RX_FIFO_ERR_DROP_EN: when defined, events carrying a parity or
//   framing error are counted in err_drop_count instead of being stored.
//   When undefined, every event is stored and err_drop_count reads 0.

module uart_rx_fifo #(
  parameter int UART_SIZE = 8,
  parameter int DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [UART_SIZE-1:0]       rx_data,
  input  logic                       done,
  input  logic                       crc_error,
  input  logic                       stop_error,
  input  logic                       flush,
  input  logic                       clear_overflow,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [UART_SIZE-1:0]       rd_data,
  output logic                       rd_parity_err,
  output logic                       rd_frame_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic [7:0]                 err_drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = UART_SIZE + 2;

  // Entry layout: [EW-1] frame_err, [EW-2] parity_err, [UART_SIZE-1:0] data
  logic [EW-1:0] mem [DEPTH];

  logic          stop_err_q_reg;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          empty_reg, full_reg;
  logic          overflow_reg;
  logic [EW-1:0] head_reg;

  logic          frame_evt;
  logic          push_evt;
  logic          store_evt;
  logic          pop;
  logic          wr_en;
  logic          ovf_drop;
  logic          head_bypass;
  logic [EW-1:0] wr_entry;

  // A held framing error yields a single event on its rising edge only.
  assign frame_evt = stop_error & ~stop_err_q_reg;
  assign push_evt  = done | frame_evt;
  assign wr_entry  = {frame_evt, crc_error,
                      frame_evt ? {UART_SIZE{1'b0}} : rx_data};

  assign pop = ~empty_reg & rd_ready;

`ifdef UART_RX_FIFO_ERR_DROP_EN
  logic       is_err;
  logic       err_evt;
  logic [7:0] err_drop_count_reg;

  assign is_err    = frame_evt | crc_error;
  assign store_evt = push_evt & ~is_err;
  // Events discarded by flush do not count as error drops.
  assign err_evt   = push_evt & is_err & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_drop_count_reg <= 8'd0;
    end else if (err_evt && err_drop_count_reg != 8'hFF) begin
      err_drop_count_reg <= err_drop_count_reg + 8'd1;
    end
  end

  assign err_drop_count = err_drop_count_reg;
`else
  assign store_evt      = push_evt;
  assign err_drop_count = 8'd0;
`endif

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign wr_en    = store_evt & ~flush & (~full_reg | pop);
  assign ovf_drop = store_evt & ~flush & full_reg & ~pop;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_en) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)   rd_ptr_next = rd_ptr_reg + AW'(1);
      count_next = count_reg + CW'(wr_en) - CW'(pop);
    end
  end

  // The new entry lands exactly where the next head will be read (FIFO was
  // empty, or held one entry that is being popped): forward it directly.
  assign head_bypass = wr_en & (wr_ptr_reg == rd_ptr_next);

  // Storage array, no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stop_err_q_reg <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      empty_reg      <= 1'b1;
      full_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      head_reg       <= '0;
    end else begin
      stop_err_q_reg <= stop_error;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      empty_reg      <= (count_next == '0);
      full_reg       <= (count_next == CW'(DEPTH));
      // Drop wins over a simultaneous clear.
      if (ovf_drop) begin
        overflow_reg <= 1'b1;
      end else if (clear_overflow) begin
        overflow_reg <= 1'b0;
      end
      // Head register only reloads when the head actually changes, so the
      // rd_* outputs stay put while nothing is popped or newly exposed.
      if (head_bypass) begin
        head_reg <= wr_entry;
      end else if (pop) begin
        head_reg <= mem[rd_ptr_next];
      end
    end
  end

  assign rd_valid      = ~empty_reg;
  assign rd_data       = head_reg[UART_SIZE-1:0];
  assign rd_parity_err = head_reg[UART_SIZE];
  assign rd_frame_err  = head_reg[UART_SIZE+1];
  assign count         = count_reg;
  assign empty         = empty_reg;
  assign full          = full_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: a queue-based reference model checked against
// the DUT on every falling edge, plus hand-computed literal expectations.

module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  localparam int S_DATA  = 0;
  localparam int S_COUNT = 1;
  localparam int S_OVF   = 2;
  localparam int S_ERRC  = 3;
  localparam int S_FERR  = 4;
  localparam int S_PERR  = 5;
  localparam int S_EMPTY = 6;
  localparam int S_FULL  = 7;
  localparam int S_VALID = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       done;
  logic       crc_error;
  logic       stop_error;
  logic       flush;
  logic       clear_overflow;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_parity_err;
  logic       rd_frame_err;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic [7:0] err_drop_count;

  uart_rx_fifo #(.UART_SIZE(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .done(done),
    .crc_error(crc_error), .stop_error(stop_error), .flush(flush),
    .clear_overflow(clear_overflow), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err),
    .count(count), .empty(empty), .full(full), .overflow(overflow),
    .err_drop_count(err_drop_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Entry = {frame_err, parity_err, data}
  logic [9:0] q[$];
  logic       m_ovf;
  int         m_errc;
  logic       m_prev_stop;
  logic       started = 1'b0;

  always @(posedge clk) begin
    logic       fe;
    logic       evt;
    logic [9:0] ent;
    logic       popping;
    started = 1'b1;
    if (reset) begin
      q.delete();
      m_ovf       = 1'b0;
      m_errc      = 0;
      m_prev_stop = 1'b0;
    end else begin
      fe      = stop_error & ~m_prev_stop;
      evt     = done | fe;
      ent     = {fe, crc_error, fe ? 8'h00 : rx_data};
      popping = (q.size() != 0) && rd_ready;
      if (clear_overflow) m_ovf = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        if (popping) void'(q.pop_front());
        if (evt) begin
`ifdef UART_RX_FIFO_ERR_DROP_EN
          if (ent[9] || ent[8]) begin
            if (m_errc < 255) m_errc = m_errc + 1;
          end else
`endif
          if (q.size() < DEPTH) q.push_back(ent);
          else m_ovf = 1'b1;
        end
      end
      m_prev_stop = stop_error;
    end
  end

  // ---------------- compare process ----------------
  int    checks = 0;
  int    errors = 0;
  logic  lit_valid = 1'b0;
  int    lit_sel;
  int    lit_val;
  string lit_name;

  function automatic int pick(input int sel);
    case (sel)
      S_DATA:  return int'(rd_data);
      S_COUNT: return int'(count);
      S_OVF:   return int'(overflow);
      S_ERRC:  return int'(err_drop_count);
      S_FERR:  return int'(rd_frame_err);
      S_PERR:  return int'(rd_parity_err);
      S_EMPTY: return int'(empty);
      S_FULL:  return int'(full);
      default: return int'(rd_valid);
    endcase
  endfunction

  always @(negedge clk) begin
    if (started) begin
      checks = checks + 6;
      if (rd_valid !== (q.size() != 0)) begin
        errors = errors + 1;
        $display("FAIL rd_valid got %0b want %0b", rd_valid, q.size() != 0);
      end
      if (int'(count) != q.size()) begin
        errors = errors + 1;
        $display("FAIL count got %0d want %0d", count, q.size());
      end
      if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
        errors = errors + 1;
        $display("FAIL empty_full got %0b/%0b want %0b/%0b", empty, full,
                 q.size() == 0, q.size() == DEPTH);
      end
      if (overflow !== m_ovf) begin
        errors = errors + 1;
        $display("FAIL overflow got %0b want %0b", overflow, m_ovf);
      end
      if (int'(err_drop_count) != m_errc) begin
        errors = errors + 1;
        $display("FAIL err_drop_count got %0d want %0d", err_drop_count, m_errc);
      end
      if (q.size() != 0 && {rd_frame_err, rd_parity_err, rd_data} !== q[0]) begin
        errors = errors + 1;
        $display("FAIL head got %03h want %03h",
                 {rd_frame_err, rd_parity_err, rd_data}, q[0]);
      end
      if (lit_valid) begin
        checks = checks + 1;
        if (pick(lit_sel) != lit_val) begin
          errors = errors + 1;
          $display("FAIL %s got %0h want %0h", lit_name, pick(lit_sel), lit_val);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input string nm, input int sel, input int val);
    lit_name  = nm;
    lit_sel   = sel;
    lit_val   = val;
    lit_valid = 1'b1;
    @(negedge clk);
    #1;
    lit_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic crc);
    done      = 1'b1;
    rx_data   = d;
    crc_error = crc;
    step();
    done      = 1'b0;
    crc_error = 1'b0;
    $display("push data=%02h crc=%0b count=%0d", d, crc, count);
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      $display("pop cycle %0d count=%0d", i, count);
    end
    rd_ready = 1'b0;
  endtask

  task automatic fill16();
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; done = 1'b0; crc_error = 1'b0;
    stop_error = 1'b0; flush = 1'b0; clear_overflow = 1'b0; rd_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    expect_lit("reset_valid", S_VALID, 0);
    expect_lit("reset_data", S_DATA, 0);
    expect_lit("reset_empty", S_EMPTY, 1);

    // single frame
    push(8'hA5, 1'b0);
    expect_lit("a5_data", S_DATA, 8'hA5);
    expect_lit("a5_count", S_COUNT, 1);
    expect_lit("a5_valid", S_VALID, 1);
    drain(1);
    expect_lit("a5_empty_after_pop", S_EMPTY, 1);

    // parity-errored frame
    push(8'h77, 1'b1);
`ifdef UART_RX_FIFO_ERR_DROP_EN
    expect_lit("crc_dropped_count", S_COUNT, 0);
    expect_lit("crc_errc", S_ERRC, 1);
`else
    expect_lit("crc_stored_perr", S_PERR, 1);
    expect_lit("crc_stored_data", S_DATA, 8'h77);
    drain(1);
`endif
    // 300 errored events, consumer always ready
    done = 1'b1; crc_error = 1'b1; rd_ready = 1'b1; rx_data = 8'h11;
    repeat (300) step();
    done = 1'b0; crc_error = 1'b0;
    drain(2);
`ifdef UART_RX_FIFO_ERR_DROP_EN
    expect_lit("errc_saturated", S_ERRC, 255);
`else
    expect_lit("errc_tied_zero", S_ERRC, 0);
`endif

    // fill, overflow, drain in order
    fill16();
    expect_lit("full_after_16", S_FULL, 1);
    push(8'hFF, 1'b0);
    expect_lit("ovf_set", S_OVF, 1);
    expect_lit("ovf_count", S_COUNT, 16);
    expect_lit("ovf_head", S_DATA, 8'h00);
    drain(16);
    expect_lit("drained_empty", S_EMPTY, 1);
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    expect_lit("ovf_cleared", S_OVF, 0);

    // full FIFO, simultaneous push and pop
    fill16();
    rd_ready = 1'b1;
    push(8'h55, 1'b0);
    rd_ready = 1'b0;
    expect_lit("pushpop_count", S_COUNT, 16);
    expect_lit("pushpop_head", S_DATA, 8'h01);
    expect_lit("pushpop_no_ovf", S_OVF, 0);
    drain(15);
    expect_lit("pushpop_last", S_DATA, 8'h55);
    drain(1);

    // held framing error followed by a good frame
    stop_error = 1'b1;
    repeat (3) step();
    stop_error = 1'b0;
    push(8'h3C, 1'b0);
`ifdef UART_RX_FIFO_ERR_DROP_EN
    expect_lit("ferr_drop_count", S_COUNT, 1);
    expect_lit("ferr_drop_data", S_DATA, 8'h3C);
    drain(1);
`else
    expect_lit("ferr_count", S_COUNT, 2);
    expect_lit("ferr_flag", S_FERR, 1);
    expect_lit("ferr_data", S_DATA, 8'h00);
    drain(1);
    expect_lit("good_data", S_DATA, 8'h3C);
    expect_lit("good_flag", S_FERR, 0);
    drain(1);
`endif

    // flush with 5 entries and overflow set, simultaneous push
    fill16();
    push(8'hEE, 1'b0);
    drain(11);
    expect_lit("pre_flush_count", S_COUNT, 5);
    flush = 1'b1;
    push(8'h99, 1'b0);
    flush = 1'b0;
    expect_lit("flush_count", S_COUNT, 0);
    expect_lit("flush_empty", S_EMPTY, 1);
    expect_lit("flush_ovf_kept", S_OVF, 1);
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;

    // reset mid-operation with stop_error held through it
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    stop_error = 1'b1;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
`ifdef UART_RX_FIFO_ERR_DROP_EN
    expect_lit("rst_evt_errc", S_ERRC, 1);
    expect_lit("rst_evt_count", S_COUNT, 0);
`else
    expect_lit("rst_evt_count", S_COUNT, 1);
    expect_lit("rst_evt_ferr", S_FERR, 1);
`endif
    stop_error = 1'b0;
    drain(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side frame buffer sitting directly downstream of the UART receiver. Captures each completed frame (data plus parity/framing status) from the receiver's `done`/`stop_error` outputs into a DEPTH-entry circular FIFO. Presents the frames to the host/bus side through a valid/ready read port with first-word-fall-through. Provides occupancy, sticky overflow and flush control.

## Interface
- `UART_SIZE`, 8, data bits per frame; matches the receiver.
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  UART_SIZE  receiver data word, valid in the cycle `done`=1.
- `done`  in  1  one-cycle pulse: frame received with good stop bit.
- `crc_error`  in  1  receiver parity-error level, sampled at each push event.
- `stop_error`  in  1  receiver framing-error level; its rising edge is a push event.
- `flush`  in  1  discard all entries.
- `clear_overflow`  in  1  clears sticky `overflow`.
- `rd_valid`  out  1  head entry available.
- `rd_ready`  in  1  consumer accepts head entry when `rd_valid`&`rd_ready`.
- `rd_data`  out  UART_SIZE  head entry data.
- `rd_parity_err`  out  1  head entry parity-error flag.
- `rd_frame_err`  out  1  head entry framing-error flag.
- `count`  out  $clog2(DEPTH)+1  entries held, 0..DEPTH.
- `empty` / `full`  out  1  `count`==0 / `count`==DEPTH.
- `overflow`  out  1  sticky: at least one event was dropped because the FIFO was full.
- `err_drop_count`  out  8  saturating count of error frames discarded (see Configuration).

## Operation
- Edge detector: `stop_err_q` registers `stop_error`. `frame_evt` = `stop_error` & ~`stop_err_q`.
- Push event = `done` | `frame_evt`. Entry = {frame_err=`frame_evt`, parity_err=`crc_error`, data=`frame_evt` ? 0 : `rx_data`}.
- Two framing errors with no good frame between them give one edge only. They are recorded as one entry.
- Storage: DEPTH×(UART_SIZE+2) array, write/read pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. `count` is held separately.
- Pop = `rd_valid` & `rd_ready`. Read pointer advances and `count` decrements.
- Push when `count`<DEPTH: write at the write pointer, advance it, increment `count`.
- Push when full:
  - With a pop in the same cycle: the push is accepted and `count` is unchanged.
  - Without a pop: the entry is dropped, `overflow`←1 and pointers are unchanged.
- Push and pop in the same cycle, not full: both occur and `count` is unchanged.
- Push while empty: no pop is possible that cycle (`rd_valid`=0).
- `flush`:
  - Pointers and `count` go to 0.
  - Any push in the same cycle is discarded. It is not counted as overflow and does not count toward `err_drop_count`.
  - `overflow` is unaffected.
- `clear_overflow`: `overflow`←0. If an overflow drop occurs in the same cycle, set wins.
- `rd_*` outputs are driven from the array at the read pointer. They are don't-care but stable when `rd_valid`=0.

## Timing
- Reset values:
  - `rd_valid`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `err_drop_count`=0.
  - `rd_data`, `rd_parity_err`, `rd_frame_err` = 0.
  - Pointers = 0, `stop_err_q`=0.
- Latency: an event sampled at edge N is written at edge N. `rd_valid`=1 after edge N, i.e. one cycle of latency.
- Pop at edge M: the next entry, if present, is on `rd_*` after edge M. Throughput is one entry per cycle.
- `count`, `full`, `empty` are registered and update at the same edge as push/pop.
- Reset mid-operation discards all entries and the edge history. A `stop_error` held high through reset produces an event on the first cycle after reset.
- `rd_valid` never drops without a pop or a `flush`. `rd_*` hold stable while `rd_valid`=1 and `rd_ready`=0.

## Configuration
- `UART_RX_FIFO_ERR_DROP_EN` defined:
  - Push events with parity_err=1 or frame_err=1 are not written.
  - Each such event increments `err_drop_count`, saturating at 255. Increments happen even if the FIFO is full, and such events do not set `overflow`.
  - `err_drop_count` clears on `reset` only.
- Undefined: every event is stored as described above and `err_drop_count` is tied to 0.

## Test plan
- Reset, then `done` with `rx_data`=0xA5, `crc_error`=0 -> one cycle later `rd_valid`=1, `rd_data`=0xA5, flags 0, `count`=1. Pop -> `empty`=1.
- 16 `done` pulses with 0x00..0x0F, `rd_ready`=0 -> `full`=1. A 17th push (0xFF) -> dropped, `overflow`=1. Drain -> 0x00..0x0F in order. `clear_overflow` -> 0.
- Full FIFO, push 0x55 and pop in the same cycle -> `count` stays 16, 0x00 is popped, 0x55 appears last after draining.
- `stop_error` 0→1 held 3 cycles, then a `done` with 0x3C -> exactly two entries: {frame_err=1, data=0x00} then {frame_err=0, data=0x3C}.
- 5 entries held, `flush` asserted with a simultaneous `done` -> `count`=0, `empty`=1, `overflow` unchanged, no entry appears.
- With `UART_RX_FIFO_ERR_DROP_EN`: `done` with `crc_error`=1 -> nothing stored, `err_drop_count`=1. 300 errored events -> `err_drop_count`=255. Without the macro: the same stimulus stores the entry with `rd_parity_err`=1.
